// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-and-add multiplier. Non-MUL results take one cycle; MUL takes WIDTH+1.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_OR   = 3'b001,
        OP_AND  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SLT  = 3'b100,
        OP_SLTU = 3'b101,
        OP_MUL  = 3'b110,
        OP_ILL  = 3'b111
    } op_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               negative_q, negative_d;
    logic               illegal_q, illegal_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    op_e                op;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic               lt_s;
    logic               lt_u;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_ill;
    logic [2*WIDTH-1:0] acc_step;

    assign op    = op_e'(opcode);
    assign add_w = {1'b0, x} + {1'b0, y};
    // Bit WIDTH of the subtraction is the carry-out of x + ~y + 1, i.e. NOT borrow.
    assign sub_w = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
    assign lt_s  = $signed(x) < $signed(y);
    assign lt_u  = x < y;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (x[WIDTH-1] == y[WIDTH-1]) & (add_w[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = ~sub_w[WIDTH];
                alu_v   = (x[WIDTH-1] != y[WIDTH-1]) & (sub_w[WIDTH-1] != x[WIDTH-1]);
            end
            OP_OR:   alu_res = x | y;
            OP_AND:  alu_res = x & y;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        negative_d = negative_q;
        illegal_d  = illegal_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, x};
                        mplier_d = y;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d   = alu_res;
                        zero_d     = (alu_res == '0);
                        carry_d    = alu_c;
                        overflow_d = alu_v;
                        negative_d = alu_res[WIDTH-1];
                        illegal_d  = alu_ill;
                        state_d    = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // The last iteration's sum is written straight into the result registers.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d   = acc_step[WIDTH-1:0];
                    zero_d     = (acc_step[WIDTH-1:0] == '0);
                    carry_d    = 1'b0;
                    overflow_d = |acc_step[2*WIDTH-1:WIDTH];
                    negative_d = acc_step[WIDTH-1];
                    illegal_d  = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
            illegal_q  <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            negative_q <= negative_d;
            illegal_q  <= illegal_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign negative  = negative_q;
    assign illegal   = illegal_q;

endmodule
